// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_E     = 8'h24;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ps2_keycode_decoder_if.sv
// Connector-side PS/2 lines plus the decoded key outputs and frame FSM state.
interface ps2_keycode_decoder_if;
  import ps2_pkg::*;

  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic       ext;
  logic       key_valid;
  logic       frame_err;
  rx_state_t  rx_state;

  // key_valid and frame_err are single-cycle strobes with no back-pressure;
  // keycode/ext are levels that hold until the next accepted make or break.
  modport master (
    output PS2_CLK, PS2_DAT,
    input  keycode, ext, key_valid, frame_err, rx_state
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output keycode, ext, key_valid, frame_err, rx_state
  );

endinterface

// File: rtl/ps2_keycode_decoder_rx_frame.sv
// PS/2 device-to-host receiver: synchronizers, clock glitch filter, frame FSM
// with odd-parity check and a mid-frame inactivity timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, clk_fall;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_ok;
  logic          timeout;
  logic          bv_next, err_next;
  rx_state_t     state_next;

  // Lines idle high, so the synchronizers and filter reset high to avoid a
  // phantom falling edge coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
      clk_fall <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        clk_fall <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign timeout = (state != RX_IDLE) && !clk_fall && (timer == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bv_next    = 1'b0;
    err_next   = 1'b0;
    if (timeout) begin
      state_next = RX_IDLE;
      err_next   = 1'b1;
    end else if (clk_fall) begin
      case (state)
        RX_IDLE: begin
          if (dat_s2) err_next = 1'b1;
          else        state_next = RX_DATA;
        end
        RX_DATA: begin
          if (bit_cnt == 3'd7) state_next = RX_PARITY;
        end
        RX_PARITY: state_next = RX_STOP;
        RX_STOP: begin
          state_next = RX_IDLE;
          if (dat_s2 && par_ok) bv_next  = 1'b1;
          else                  err_next = 1'b1;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_ok     <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= bv_next;
      frame_err  <= err_next;
      if (clk_fall || state == RX_IDLE) timer <= '0;
      else                              timer <= timer + 1'b1;
      if (clk_fall) begin
        case (state)
          RX_IDLE:   bit_cnt <= '0;
          RX_DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          RX_PARITY: par_ok <= ^{shift, dat_s2};
          default:   ;
        endcase
      end
    end
  end

  assign rx_byte = shift;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard front end: turns make/break/extended scan-code bytes into a
// held-key level (keycode/ext) for the pose tracker.
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              CLOCK_50,
  input logic              reset,
  ps2_keycode_decoder_if.slave bus
);

  logic [7:0] rx_byte;
  logic       byte_valid, rx_err;
  rx_state_t  rx_state;
  logic [7:0] key_q;
  logic       ext_q, kv_q, brk, ext_pend;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (CLOCK_50),
    .rst        (reset),
    .ps2_clk    (bus.PS2_CLK),
    .ps2_dat    (bus.PS2_DAT),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_err),
    .state      (rx_state)
  );

  // Prefixes only arm the next byte; a break of anything other than the
  // held key is dropped, and a repeat of the held key is not a new press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_q    <= '0;
      ext_q    <= 1'b0;
      kv_q     <= 1'b0;
      brk      <= 1'b0;
      ext_pend <= 1'b0;
    end else begin
      kv_q <= 1'b0;
      if (rx_err) begin
        brk      <= 1'b0;
        ext_pend <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else begin
          if (brk) begin
            if ({ext_pend, rx_byte} == {ext_q, key_q}) begin
              key_q <= '0;
              ext_q <= 1'b0;
            end
          end else if ({ext_pend, rx_byte} != {ext_q, key_q}) begin
            key_q <= rx_byte;
            ext_q <= ext_pend;
            kv_q  <= (rx_byte != 8'h00);
          end
          brk      <= 1'b0;
          ext_pend <= 1'b0;
        end
      end
    end
  end

  assign bus.keycode   = key_q;
  assign bus.ext       = ext_q;
  assign bus.key_valid = kv_q;
  assign bus.frame_err = rx_err;
  assign bus.rx_state  = rx_state;

endmodule
